reg_bank_mp: RTL and testbench

Parametrised general-purpose register bank for the CPU datapath. It has one synchronous write port (busC) and two registered read ports (busA, busB), with same-cycle write-to-read bypass and an optional hardwired zero register. Depth and width are parameters. An optional scoreboard tracks registers with a pending write for hazard detection by the control unit.

---
 rtl/reg_bank_mp_if.sv | 40 ++++
 rtl/reg_bank_mp.sv | 176 +++++++++++++++++
 tb/tb_reg_bank_mp.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_mp_if.sv
// Register bank port bundle: two read ports, one write port and, with
// SCOREBOARD_EN defined, the reserve/busy hazard signals.
interface reg_bank_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] busAsel;
  logic [ADDR_W-1:0] busBsel;
  logic              enOut;
  logic [DATA_W-1:0] busA;
  logic [DATA_W-1:0] busB;
  logic              rdValid;
  logic [DATA_W-1:0] busC;
  logic [ADDR_W-1:0] busCsel;
  logic              WriteC;
`ifdef SCOREBOARD_EN
  logic              reserve;
  logic [ADDR_W-1:0] reserveSel;
  logic              busyA;
  logic              busyB;

  modport master (
    output busAsel, busBsel, enOut, busC, busCsel, WriteC, reserve, reserveSel,
    input  busA, busB, rdValid, busyA, busyB
  );
  modport slave (
    input  busAsel, busBsel, enOut, busC, busCsel, WriteC, reserve, reserveSel,
    output busA, busB, rdValid, busyA, busyB
  );
`else
  modport master (
    output busAsel, busBsel, enOut, busC, busCsel, WriteC,
    input  busA, busB, rdValid
  );
  modport slave (
    input  busAsel, busBsel, enOut, busC, busCsel, WriteC,
    output busA, busB, rdValid
  );
`endif
endinterface

// File: rtl/reg_bank_mp.sv
// General-purpose register bank: 1 write port, 2 registered read ports with
// write bypass and optional zero register. Define SCOREBOARD_EN for the busy tracker.
module reg_bank_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         reset,
  reg_bank_mp_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam bit              ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] regFile_r [DEPTH];
  logic [DATA_W-1:0] busA_r;
  logic [DATA_W-1:0] busB_r;
  logic              rdValid_r;
  logic              writeOk_s;
  logic [DATA_W-1:0] rdA_s;
  logic [DATA_W-1:0] rdB_s;

  function automatic logic inRange(input logic [ADDR_W-1:0] s);
    return ({1'b0, s} < DEPTH_C);
  endfunction

  function automatic logic isZero(input logic [ADDR_W-1:0] s);
    return ZERO_EN && (s == {ADDR_W{1'b0}});
  endfunction

  // Out-of-range and zero-register selects read 0 ahead of any bypass hit.
  function automatic logic [DATA_W-1:0] readFn(
    input logic [ADDR_W-1:0] s,
    input logic [DATA_W-1:0] stored,
    input logic              wrOk,
    input logic [ADDR_W-1:0] wSel,
    input logic [DATA_W-1:0] wData
  );
    logic [DATA_W-1:0] r;
    if (isZero(s)) begin
      r = {DATA_W{1'b0}};
    end else if (!inRange(s)) begin
      r = {DATA_W{1'b0}};
    end else if (wrOk && (wSel == s)) begin
      r = wData;
    end else begin
      r = stored;
    end
    return r;
  endfunction

  // Qualify the write request against range and zero-register exclusions.
  always_comb begin
    writeOk_s = 1'b0;
    if (bus.WriteC && inRange(bus.busCsel) && !isZero(bus.busCsel)) begin
      writeOk_s = 1'b1;
    end else begin
      writeOk_s = 1'b0;
    end
  end

  // Next read data for both ports.
  always_comb begin
    rdA_s = readFn(bus.busAsel, regFile_r[bus.busAsel], writeOk_s, bus.busCsel, bus.busC);
    rdB_s = readFn(bus.busBsel, regFile_r[bus.busBsel], writeOk_s, bus.busCsel, bus.busC);
  end

  // Register file storage; reset discards any write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regFile_r[i] <= {DATA_W{1'b0}};
      end
    end else if (writeOk_s) begin
      regFile_r[bus.busCsel] <= bus.busC;
    end
  end

  // Registered read ports and read-valid strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      busA_r    <= {DATA_W{1'b0}};
      busB_r    <= {DATA_W{1'b0}};
      rdValid_r <= 1'b0;
    end else begin
      rdValid_r <= bus.enOut;
      if (bus.enOut) begin
        busA_r <= rdA_s;
        busB_r <= rdB_s;
      end
    end
  end

  assign bus.busA    = busA_r;
  assign bus.busB    = busB_r;
  assign bus.rdValid = rdValid_r;

`ifdef SCOREBOARD_EN
  logic [DEPTH-1:0] busyVec_r;
  logic [DEPTH-1:0] busyNext_s;
  logic             reserveOk_s;
  logic             busyCapA_s;
  logic             busyCapB_s;
  logic             busyA_r;
  logic             busyB_r;

  // Reported busy reflects this cycle's write clear but not this cycle's reserve.
  function automatic logic busyFn(
    input logic [ADDR_W-1:0] s,
    input logic              busyBit,
    input logic              wrOk,
    input logic [ADDR_W-1:0] wSel
  );
    logic r;
    if (isZero(s) || !inRange(s)) begin
      r = 1'b0;
    end else if (wrOk && (wSel == s)) begin
      r = 1'b0;
    end else begin
      r = busyBit;
    end
    return r;
  endfunction

  // Qualify the reserve request like a write.
  always_comb begin
    reserveOk_s = 1'b0;
    if (bus.reserve && inRange(bus.reserveSel) && !isZero(bus.reserveSel)) begin
      reserveOk_s = 1'b1;
    end else begin
      reserveOk_s = 1'b0;
    end
  end

  // Busy vector update: reserve beats a same-cycle write clear.
  always_comb begin
    busyNext_s = busyVec_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (reserveOk_s && (bus.reserveSel == ADDR_W'(i))) begin
        busyNext_s[i] = 1'b1;
      end else if (writeOk_s && (bus.busCsel == ADDR_W'(i))) begin
        busyNext_s[i] = 1'b0;
      end else begin
        busyNext_s[i] = busyVec_r[i];
      end
    end
  end

  // Busy flags seen by each read port.
  always_comb begin
    busyCapA_s = busyFn(bus.busAsel, busyVec_r[bus.busAsel], writeOk_s, bus.busCsel);
    busyCapB_s = busyFn(bus.busBsel, busyVec_r[bus.busBsel], writeOk_s, bus.busCsel);
  end

  // Busy vector and registered busy outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      busyVec_r <= {DEPTH{1'b0}};
      busyA_r   <= 1'b0;
      busyB_r   <= 1'b0;
    end else begin
      busyVec_r <= busyNext_s;
      if (bus.enOut) begin
        busyA_r <= busyCapA_s;
        busyB_r <= busyCapB_s;
      end
    end
  end

  assign bus.busyA = busyA_r;
  assign bus.busyB = busyB_r;
`endif

endmodule

// File: tb/tb_reg_bank_mp.sv
// Scoreboard bench for reg_bank_mp: dut0 has DEPTH=24 with zero register,
// dut1 has DEPTH=32 with register 0 as an ordinary register.
module tb_reg_bank_mp;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ba;
    logic        bb;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t q0[$];
  exp_t q1[$];

  reg_bank_mp_if #(.DATA_W(32), .ADDR_W(5)) if0 ();
  reg_bank_mp_if #(.DATA_W(32), .ADDR_W(5)) if1 ();

  reg_bank_mp #(.DATA_W(32), .DEPTH(24), .ADDR_W(5), .ZERO_REG(1)) dut0 (
    .clk(clk), .reset(reset), .bus(if0)
  );
  reg_bank_mp #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(0)) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive0(input logic we, input logic [4:0] wsel, input logic [31:0] wd,
                        input logic en, input logic [4:0] as, input logic [4:0] bs);
    if0.WriteC = we; if0.busCsel = wsel; if0.busC = wd;
    if0.enOut = en; if0.busAsel = as; if0.busBsel = bs;
    @(posedge clk); #1;
  endtask

  task automatic drive1(input logic we, input logic [4:0] wsel, input logic [31:0] wd,
                        input logic en, input logic [4:0] as, input logic [4:0] bs);
    if1.WriteC = we; if1.busCsel = wsel; if1.busC = wd;
    if1.enOut = en; if1.busAsel = as; if1.busBsel = bs;
    @(posedge clk); #1;
  endtask

  task automatic exp0(input logic [31:0] a, input logic [31:0] b, input logic ba, input logic bb);
    exp_t e;
    e.a = a; e.b = b; e.ba = ba; e.bb = bb;
    q0.push_back(e);
  endtask

  task automatic exp1(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.a = a; e.b = b; e.ba = 1'b0; e.bb = 1'b0;
    q1.push_back(e);
  endtask

  // Monitor for dut0: every rdValid pops one expectation.
  always @(negedge clk) begin
    if (if0.rdValid === 1'b1) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL dut0_unexpected_rdValid: got rdValid=1 want 0");
      end else begin
        exp_t e;
        e = q0.pop_front();
        chk("dut0_busA", if0.busA, e.a);
        chk("dut0_busB", if0.busB, e.b);
`ifdef SCOREBOARD_EN
        chk("dut0_busyA", {31'd0, if0.busyA}, {31'd0, e.ba});
        chk("dut0_busyB", {31'd0, if0.busyB}, {31'd0, e.bb});
`endif
      end
    end
  end

  // Monitor for dut1.
  always @(negedge clk) begin
    if (if1.rdValid === 1'b1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1_unexpected_rdValid: got rdValid=1 want 0");
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1_busA", if1.busA, e.a);
        chk("dut1_busB", if1.busB, e.b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    if0.WriteC = 1'b0; if0.busCsel = 5'd0; if0.busC = 32'd0;
    if0.enOut = 1'b0; if0.busAsel = 5'd0; if0.busBsel = 5'd0;
    if1.WriteC = 1'b0; if1.busCsel = 5'd0; if1.busC = 32'd0;
    if1.enOut = 1'b0; if1.busAsel = 5'd0; if1.busBsel = 5'd0;
`ifdef SCOREBOARD_EN
    if0.reserve = 1'b0; if0.reserveSel = 5'd0;
    if1.reserve = 1'b0; if1.reserveSel = 5'd0;
`endif
    reset = 1'b1;
    drive0(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    drive0(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    reset = 1'b0;
    chk("reset_rdValid", {31'd0, if0.rdValid}, 32'd0);
    chk("reset_busA", if0.busA, 32'd0);
    chk("reset_busB", if0.busB, 32'd0);

    // Write then read back, then reset with a write in flight.
    drive0(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
    exp0(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0);
    drive0(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5);
    reset = 1'b1;
    drive0(1'b1, 5'd5, 32'h11111111, 1'b1, 5'd5, 5'd5);
    reset = 1'b0;
    chk("in_reset_rdValid", {31'd0, if0.rdValid}, 32'd0);
    chk("in_reset_busA", if0.busA, 32'd0);
    exp0(32'd0, 32'd0, 1'b0, 1'b0);
    drive0(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5);

    // Write/read latency and hold with enOut=0.
    drive0(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 5'd0);
    exp0(32'h12345678, 32'd0, 1'b0, 1'b0);
    drive0(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd5);
    drive0(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd5);
    chk("hold_busA", if0.busA, 32'h12345678);
    chk("hold_rdValid", {31'd0, if0.rdValid}, 32'd0);

    // Bypass; WriteC=0 with matching select must not bypass.
    exp0(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0);
    drive0(1'b1, 5'd9, 32'hA5A5A5A5, 1'b1, 5'd9, 5'd9);
    exp0(32'hA5A5A5A5, 32'h12345678, 1'b0, 1'b0);
    drive0(1'b0, 5'd9, 32'hFFFF0000, 1'b1, 5'd9, 5'd7);

    // Zero register.
    exp0(32'd0, 32'hA5A5A5A5, 1'b0, 1'b0);
    drive0(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd9);
    exp0(32'd0, 32'd0, 1'b0, 1'b0);
    drive0(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);

    // Range limits for DEPTH=24.
    exp0(32'd0, 32'd0, 1'b0, 1'b0);
    drive0(1'b1, 5'd30, 32'h1, 1'b1, 5'd30, 5'd23);
    exp0(32'd0, 32'd0, 1'b0, 1'b0);
    drive0(1'b1, 5'd24, 32'h2, 1'b1, 5'd24, 5'd30);
    exp0(32'd0, 32'hA5A5A5A5, 1'b0, 1'b0);
    drive0(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd9);
    exp0(32'd0, 32'd0, 1'b0, 1'b0);
    drive0(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 5'd6);
    exp0(32'h23, 32'h12345678, 1'b0, 1'b0);
    drive0(1'b1, 5'd23, 32'h23, 1'b1, 5'd23, 5'd7);
    exp0(32'h23, 32'd0, 1'b0, 1'b0);
    drive0(1'b0, 5'd0, 32'd0, 1'b1, 5'd23, 5'd31);

`ifdef SCOREBOARD_EN
    // Reserve is invisible to a read in the same cycle, visible next cycle.
    if0.reserve = 1'b1; if0.reserveSel = 5'd3;
    exp0(32'd0, 32'd0, 1'b0, 1'b0);
    drive0(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3);
    if0.reserve = 1'b0;
    exp0(32'd0, 32'd0, 1'b1, 1'b0);
    drive0(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd4);
    exp0(32'h33, 32'h33, 1'b0, 1'b0);
    drive0(1'b1, 5'd3, 32'h33, 1'b1, 5'd3, 5'd3);
    exp0(32'h33, 32'h33, 1'b0, 1'b0);
    drive0(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3);
    // Reserve and write to the same register: reserve wins.
    if0.reserve = 1'b1; if0.reserveSel = 5'd4;
    drive0(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 5'd0);
    if0.reserve = 1'b0;
    exp0(32'h44, 32'h33, 1'b1, 1'b0);
    drive0(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd3);
    drive0(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    chk("hold_busyA", {31'd0, if0.busyA}, 32'd1);
    // Excluded reserves (reg 0, out of range) and the last valid register.
    if0.reserve = 1'b1; if0.reserveSel = 5'd0;
    drive0(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    if0.reserveSel = 5'd30;
    drive0(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    if0.reserveSel = 5'd23;
    drive0(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    if0.reserve = 1'b0;
    exp0(32'd0, 32'd0, 1'b0, 1'b0);
    drive0(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd30);
    exp0(32'h23, 32'h44, 1'b1, 1'b1);
    drive0(1'b0, 5'd0, 32'd0, 1'b1, 5'd23, 5'd4);
`endif
    drive0(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);

    // dut1: register 0 is ordinary, DEPTH=32 so register 31 is valid.
    exp1(32'hFFFFFFFF, 32'd0);
    drive1(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd31);
    exp1(32'hFFFFFFFF, 32'hFFFFFFFF);
    drive1(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
    exp1(32'hCAFE0031, 32'hFFFFFFFF);
    drive1(1'b1, 5'd31, 32'hCAFE0031, 1'b1, 5'd31, 5'd0);
    exp1(32'd0, 32'hCAFE0031);
    drive1(1'b0, 5'd0, 32'd0, 1'b1, 5'd30, 5'd31);
    drive1(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("dut0_queue_drained", q0.size(), 32'd0);
    chk("dut1_queue_drained", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
